// File: rtl/msk_par2ser.sv
// Masked parallel-to-serial unloader: loads nwords masked elements at once and
// emits them lowest element first, one per accepted transfer. Shares are only moved or held.
module msk_par2ser #(
  parameter int d      = 2,
  parameter int count  = 1,
  parameter int nwords = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [nwords*count*d-1:0]   in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [count*d-1:0]          out
);

  localparam int EW = count * d;
  localparam int SW = nwords * EW;
  localparam int IW = (nwords > 1) ? $clog2(nwords) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [SW-1:0]   r_sreg;
  logic [SW-1:0]   w_shift;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_next;
  logic            w_last;
  logic            w_in_fire;
  logic            w_out_fire;

  assign w_last = (r_idx == IW'(nwords - 1));

  // Shift view: each element takes its upper neighbour, the top element becomes all-zero shares.
  for (genvar gi = 0; gi < nwords; gi++) begin : g_elem
    if (gi == nwords - 1) begin : g_top
      assign w_shift[gi*EW +: EW] = '0;
    end else begin : g_mid
      assign w_shift[gi*EW +: EW] = r_sreg[(gi+1)*EW +: EW];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_BUSY: begin
        out_valid = 1'b1;
        in_ready  = out_ready & w_last;
      end
      default: ;
    endcase
    w_in_fire  = in_valid & in_ready;
    w_out_fire = out_valid & out_ready;
    // A load in the same cycle as the last element leaving wins over the shift.
    if (w_in_fire) begin
      w_state_next = S_BUSY;
      w_idx_next   = '0;
    end else if (w_out_fire) begin
      if (w_last) begin
        w_state_next = S_IDLE;
        w_idx_next   = '0;
      end else begin
        w_idx_next = r_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_sreg  <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (w_in_fire) begin
        r_sreg <= in;
      end else if (w_out_fire) begin
        r_sreg <= w_shift;
      end
    end
  end

  assign out = r_sreg[EW-1:0];

endmodule

// File: tb/tb_msk_par2ser.sv
// Directed and randomized checks of msk_par2ser with d=2, count=1, nwords=4.
module tb_msk_par2ser;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] dout;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];
  logic       fired_in;
  logic       fired_out;
  logic [7:0] loaded_word;

  msk_par2ser #(.d(2), .count(1), .nwords(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sample handshakes at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    fired_in  = in_valid & in_ready;
    fired_out = out_valid & out_ready;
    if (fired_in) begin
      loaded_word = din;
      $display("load  word=%02h", din);
    end
    if (fired_out) begin
      got_q.push_back(dout);
      $display("xfer  elem=%02b", dout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_e%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[2*k +: 2]);
  endtask

  initial begin
    int words;
    logic [1:0] g;
    logic [1:0] e;
    rst_n = 1'b0; in_valid = 1'b0; din = 8'h00; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out",       dout,      2'b00);
    @(posedge clk); #1; rst_n = 1'b1;

    // Single word with a free-flowing sink
    got_q.delete(); exp_q.delete();
    din = 8'hE4; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid_after_load", out_valid, 1'b1);
    chk("single_first_elem", dout, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("single_consec%0d", i), fired_out, 1'b1);
    end
    chk("single_idle_valid", out_valid, 1'b0);
    chk("single_idle_ready", in_ready, 1'b1);
    exp_q = '{2'b00, 2'b01, 2'b10, 2'b11};
    cmp_stream("single");

    // Backpressure: sink stalls for three cycles after the first element
    got_q.delete();
    din = 8'hE4; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), dout, 2'b01);
      chk($sformatf("bp_valid%0d", i), out_valid, 1'b1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    cmp_stream("bp");
    chk("bp_idle", out_valid, 1'b0);

    // Back-to-back words with a same-cycle reload
    got_q.delete();
    din = 8'hE4; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    din = 8'h1B;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("b2b_ready%0d", i), fired_in, (i == 3) ? 1'b1 : 1'b0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("b2b_nogap%0d", i), fired_out, 1'b1);
    end
    exp_q = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    cmp_stream("b2b");

    // Reset mid-word discards the remainder
    got_q.delete();
    din = 8'hE4; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("mid_out_before_rst", dout, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_out", dout, 2'b00);
    @(posedge clk); #1; rst_n = 1'b1;
    got_q.delete();
    for (int i = 0; i < 6; i++) tick();
    chk("mid_no_stale", got_q.size(), 0);
    din = 8'h1B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    exp_q = '{2'b11, 2'b10, 2'b01, 2'b00};
    cmp_stream("mid_next");

    // Randomized shares against an unmasked reference stream
    got_q.delete(); exp_q.delete();
    words = 0;
    din = 8'($urandom); in_valid = 1'b1;
    for (int c = 0; c < 600 && words < 20; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (fired_in) begin
        push_word(loaded_word);
        words++;
        din = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("rand_words_loaded", words, 20);
    for (int c = 0; c < 300 && got_q.size() < exp_q.size(); c++) begin
      out_ready = ($urandom_range(0, 1) != 0);
      tick();
    end
    chk("rand_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      g = got_q[i];
      e = exp_q[i];
      chk($sformatf("rand_s0_%0d", i), g[0], e[0]);
      chk($sformatf("rand_s1_%0d", i), g[1], e[1]);
      chk($sformatf("rand_xor_%0d", i), g[0] ^ g[1], e[0] ^ e[1]);
    end
    out_ready = 1'b1;
    tick();
    chk("rand_idle", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
